// File: rtl/vga_scan_controller_if.sv
// Scan controller bus: line prefetch req/ack handshake plus the timed video outputs.
// Latency: none, signal bundle only.
// Backpressure: line_req/line_idx are held by the controller until line_ack is seen.
interface vga_scan_controller_if #(
  parameter int HDISP = 640,
  parameter int VDISP = 480
);
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  logic          line_req;
  logic [YW-1:0] line_idx;
  logic          line_ack;
  logic          vga_HS;
  logic          vga_VS;
  logic          vga_BLANK;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_start;
  logic          underflow;

  // Controller side
  modport master (
    output line_req, line_idx, vga_HS, vga_VS, vga_BLANK,
           pix_x, pix_y, frame_start, underflow,
    input  line_ack
  );

  // Framebuffer reader / display side
  modport slave (
    input  line_req, line_idx, vga_HS, vga_VS, vga_BLANK,
           pix_x, pix_y, frame_start, underflow,
    output line_ack
  );
endinterface

// File: rtl/vga_scan_controller.sv
// VGA scan controller: h/v timing, blanking, pixel coordinates and one-line-ahead prefetch.
// Latency: all outputs registered and aligned to the internal (h,v) counters of the same cycle.
// Backpressure: a request is held until acked; a late ack raises sticky underflow, scan never stalls.
module vga_scan_controller #(
  parameter int HDISP  = 640,
  parameter int HFP    = 16,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VDISP  = 480,
  parameter int VFP    = 11,
  parameter int VPULSE = 2,
  parameter int VBP    = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  vga_scan_controller_if.master bus
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);

  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_DISP  = HW'(HDISP);
  localparam logic [HW-1:0] H_SYNC0 = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SYNC1 = HW'(HDISP + HFP + HPULSE);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_DISP  = VW'(VDISP);
  localparam logic [VW-1:0] V_PRE   = VW'(VDISP - 1);
  localparam logic [VW-1:0] V_SYNC0 = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SYNC1 = VW'(VDISP + VFP + VPULSE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_line_req;
  logic [YW-1:0] r_line_idx;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic          r_frame_start;
  logic          r_underflow;

  logic [HW-1:0] w_nh;
  logic [VW-1:0] w_nv;
  logic          w_frame_end;
  logic          w_hs;
  logic          w_vs;
  logic          w_blank;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;

  // Next counter position and the timing outputs that belong to it, so the
  // registered outputs line up with the counters they were computed from.
  always_comb begin
    w_frame_end = (r_h == H_LAST) && (r_v == V_LAST);
    w_nh        = (r_h == H_LAST) ? '0 : r_h + 1'b1;
    w_nv        = r_v;
    if (r_h == H_LAST) begin
      w_nv = (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end
    w_hs    = !((w_nh >= H_SYNC0) && (w_nh < H_SYNC1));
    w_vs    = !((w_nv >= V_SYNC0) && (w_nv < V_SYNC1));
    w_blank = (w_nh < H_DISP) && (w_nv < V_DISP);
    w_px    = w_blank ? w_nh[XW-1:0] : '0;
    w_py    = w_blank ? w_nv[YW-1:0] : '0;
  end

  // Controller FSM, scan counters, prefetch handshake and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_h           <= '0;
      r_v           <= '0;
      r_line_req    <= 1'b0;
      r_line_idx    <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      // An ack retires the outstanding request; ack without a request is ignored.
      if (r_line_req && bus.line_ack) begin
        r_line_req <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state    <= S_PRIME;
            r_line_req <= 1'b1;
            r_line_idx <= '0;
          end
        end

        // Line 0 must be buffered before the first pixel; en is ignored here.
        S_PRIME: begin
          if (bus.line_ack) begin
            r_state       <= S_RUN;
            r_h           <= '0;
            r_v           <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b1;
          end
        end

        S_RUN: begin
          if (w_frame_end && !en) begin
            // Frame finished with scan disabled: park with idle outputs.
            r_state       <= S_IDLE;
            r_h           <= '0;
            r_v           <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
          end else begin
            r_h           <= w_nh;
            r_v           <= w_nv;
            r_hs          <= w_hs;
            r_vs          <= w_vs;
            r_blank       <= w_blank;
            r_pix_x       <= w_px;
            r_pix_y       <= w_py;
            r_frame_start <= (w_nh == '0) && (w_nv == '0);

            // Starting a display line while its fetch is still unacked.
            if ((w_nh == '0) && (w_nv < V_DISP) && r_line_req && !bus.line_ack) begin
              r_underflow <= 1'b1;
            end

            // Prefetch the next line at the start of the front porch. A request
            // still pending (even one acked this cycle) causes this slot to be skipped.
            if ((w_nh == H_DISP) && !r_line_req) begin
              if (w_nv < V_PRE) begin
                r_line_req <= 1'b1;
                r_line_idx <= w_nv[YW-1:0] + 1'b1;
              end else if ((w_nv == V_LAST) && en) begin
                r_line_req <= 1'b1;
                r_line_idx <= '0;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.line_req    = r_line_req;
  assign bus.line_idx    = r_line_idx;
  assign bus.vga_HS      = r_hs;
  assign bus.vga_VS      = r_vs;
  assign bus.vga_BLANK   = r_blank;
  assign bus.pix_x       = r_pix_x;
  assign bus.pix_y       = r_pix_y;
  assign bus.frame_start = r_frame_start;
  assign bus.underflow   = r_underflow;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller with small timing parameters.
// Reference: cycle-count based model (h,v derived from time since scan start).
// Stimulus: directed phases followed by randomized en/ack/rst traffic.
module tb_vga_scan_controller;

  localparam int HDISP = 8, HFP = 2, HPULSE = 3, HBP = 2;
  localparam int VDISP = 4, VFP = 1, VPULSE = 2, VBP = 1;
  localparam int HT = HDISP + HFP + HPULSE + HBP;
  localparam int VT = VDISP + VFP + VPULSE + VBP;

  logic clk = 1'b0;
  logic rst;
  logic en;

  int n_chk = 0;
  int n_err = 0;

  vga_scan_controller_if #(.HDISP(HDISP), .VDISP(VDISP)) bus ();

  vga_scan_controller #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: mode 0=idle, 1=prime, 2=scanning; m_t = cycles since scan start.
  int m_mode = 0;
  int m_t    = 0;
  bit m_req  = 0;
  int m_idx  = 0;
  bit m_uf   = 0;

  // Ack responder settings
  int  d_lo = 0, d_hi = 0, cur_d = 0, wait_cnt = 0;
  bit  noise = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_delay(input int lo, input int hi);
    d_lo     = lo;
    d_hi     = hi;
    cur_d    = $urandom_range(hi, lo);
    wait_cnt = 0;
  endtask

  // Reader behaviour: ack after cur_d cycles of a visible request, optional stray acks otherwise.
  task automatic respond();
    if (bus.line_req === 1'b1) begin
      if (wait_cnt >= cur_d) begin
        bus.line_ack = 1'b1;
        wait_cnt     = 0;
        cur_d        = $urandom_range(d_hi, d_lo);
      end else begin
        bus.line_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.line_ack = noise ? ($urandom_range(3, 0) == 0) : 1'b0;
      wait_cnt     = 0;
    end
  endtask

  // Advance the model across one clock edge with the inputs that edge sampled.
  task automatic model_edge(input bit r, input bit e, input bit a);
    int h, v, nh, nv;
    bit was;
    if (r) begin
      m_mode = 0; m_t = 0; m_req = 0; m_idx = 0; m_uf = 0;
      return;
    end
    was = m_req;
    if (m_req && a) m_req = 0;
    case (m_mode)
      0: if (e) begin m_mode = 1; m_req = 1; m_idx = 0; end
      1: if (a) begin m_mode = 2; m_t = 0; end
      default: begin
        h = m_t % HT;
        v = (m_t / HT) % VT;
        if (h == HT - 1 && v == VT - 1 && !e) begin
          m_mode = 0;
        end else begin
          m_t++;
          nh = m_t % HT;
          nv = (m_t / HT) % VT;
          if (nh == 0 && nv < VDISP && was && !a) m_uf = 1;
          if (nh == HDISP && !was) begin
            if (nv < VDISP - 1) begin m_req = 1; m_idx = nv + 1; end
            else if (nv == VT - 1 && e) begin m_req = 1; m_idx = 0; end
          end
        end
      end
    endcase
  endtask

  task automatic compare();
    int h, v;
    bit e_hs, e_vs, e_bl, e_fs;
    int e_px, e_py;
    e_hs = 1; e_vs = 1; e_bl = 0; e_fs = 0; e_px = 0; e_py = 0;
    if (m_mode == 2) begin
      h    = m_t % HT;
      v    = (m_t / HT) % VT;
      e_hs = !(h >= HDISP + HFP && h < HDISP + HFP + HPULSE);
      e_vs = !(v >= VDISP + VFP && v < VDISP + VFP + VPULSE);
      e_bl = (h < HDISP) && (v < VDISP);
      e_px = e_bl ? h : 0;
      e_py = e_bl ? v : 0;
      e_fs = (m_t % (HT * VT)) == 0;
    end
    chk("line_req",    bus.line_req,    m_req);
    chk("line_idx",    bus.line_idx,    m_idx);
    chk("vga_HS",      bus.vga_HS,      e_hs);
    chk("vga_VS",      bus.vga_VS,      e_vs);
    chk("vga_BLANK",   bus.vga_BLANK,   e_bl);
    chk("pix_x",       bus.pix_x,       e_px);
    chk("pix_y",       bus.pix_y,       e_py);
    chk("frame_start", bus.frame_start, e_fs);
    chk("underflow",   bus.underflow,   m_uf);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      respond();
      @(posedge clk);
      model_edge(rst, en, bus.line_ack);
      @(negedge clk);
      compare();
    end
  endtask

  // Step until the model reaches line v, column h of a running scan, within a cycle budget.
  task automatic run_to(input int v, input int h, input string tag);
    int guard;
    guard = 0;
    while (!(m_mode == 2 && (m_t / HT) % VT == v && m_t % HT == h) && guard < 400) begin
      cyc(1);
      guard++;
    end
    chk(tag, (guard < 400), 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    en           = 1'b1;
    bus.line_ack = 1'b0;

    // Reset held with en=1: outputs idle, no request.
    cyc(3);

    // Prime with a slow ack, then free run with immediate acks.
    rst = 1'b0;
    set_delay(5, 5);
    cyc(10);
    set_delay(0, 0);
    cyc(2 * HT * VT);

    // Slow reader: fetches miss their line start, underflow latches.
    run_to(1, 9, "reach_v1");
    set_delay(HT - 1, HT - 1);
    cyc(2 * HT);
    set_delay(0, 0);
    cyc(HT * VT + 10);

    // Disable mid-frame: frame completes, controller idles, then re-primes.
    run_to(2, 0, "reach_v2");
    en = 1'b0;
    cyc(HT * VT);
    en = 1'b1;
    set_delay(2, 2);
    cyc(40);

    // Reset while a request is outstanding.
    set_delay(30, 30);
    run_to(3, 5, "reach_v3");
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    set_delay(0, 2);
    cyc(60);

    // Randomized traffic: jittery acks, stray acks, en toggles, occasional reset.
    noise = 1;
    set_delay(0, 6);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(149, 0) == 0) en = ~en;
      rst = ($urandom_range(799, 0) == 0);
      cyc(1);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
